// File: rtl/cbs_sub_seq.sv
// cbs_sub_seq: multi-cycle sliced subtractor.
// Computes diff = a - b - bin one SLICE-bit slice per clock, LSB slice first,
// rippling the borrow between slices. Valid/ready handshake on both sides;
// a new operand set is only accepted in IDLE.
module cbs_sub_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] d;
    logic             borrow_next;
    logic [WIDTH-1:0] diff_new;
    logic             last;
    logic             accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Current slice subtraction and the full diff including this slice
    always_comb begin
        accept   = in_valid & in_ready;
        last     = (cnt == CW'(NSLICE - 1));
        a_slice  = a_reg[cnt*SLICE +: SLICE];
        b_slice  = b_reg[cnt*SLICE +: SLICE];
        // Bit SLICE of the widened difference is set exactly when the slice underflows
        {borrow_next, d} = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE{1'b0}}, borrow};
        diff_new = diff;
        diff_new[cnt*SLICE +: SLICE] = d;
    end

    // Operand capture, slice sequencing and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    diff   <= diff_new;
                    borrow <= borrow_next;
                    if (last) begin
                        cnt  <= '0;
                        bout <= borrow_next;
                        ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                (diff_new[WIDTH-1] != a_reg[WIDTH-1]);
                        zero <= (diff_new == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cbs_sub_seq.md
Name: cbs_sub_seq

Overview:
- Multi-cycle unsigned/two's-complement subtractor, the inverse operation of the sliced carry-bypass adder chain.
- Computes a - b - bin one SLICE-bit slice per clock, LSB slice first, carrying the borrow between slices.
- Uses a valid/ready handshake on both input and output, so it can sit directly on the datapath between register stages.

Parameters:
WIDTH, 32, operand and result width in bits.
SLICE, 8, bits processed per clock; WIDTH must be an integer multiple of SLICE.
(Derived constant NSLICE = WIDTH/SLICE, default 4. This is not an overridable parameter.)

Ports:
clk        input   1      single clock; all state updates on the rising edge.
rst_n      input   1      asynchronous, active-low reset.
in_valid   input   1      operands present on a/b/bin.
in_ready   output  1      block can accept operands; high only in IDLE.
a          input   WIDTH  minuend.
b          input   WIDTH  subtrahend.
bin        input   1      borrow-in.
out_valid  output  1      result valid; high only in DONE.
out_ready  input   1      downstream accepts the result.
diff       output  WIDTH  a - b - bin, modulo 2^WIDTH.
bout       output  1      final borrow; 1 iff a < b + bin (unsigned).
ovf        output  1      signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].
zero       output  1      diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; slice counter = 0; borrow register = 0.
  - Internal operand registers are cleared.
  - diff = 0, bout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready = 1 as soon as reset asserts.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from state registers only.
- IDLE:
  - On an edge with in_valid & in_ready, latch a, b and bin (bin goes into the borrow register).
  - Clear the slice counter and go to RUN.
  - Otherwise stay in IDLE.
- RUN, slice k = counter value:
  - Each edge computes {borrow_next, d} = a[k*SLICE +: SLICE] - b[k*SLICE +: SLICE] - borrow.
  - d is written to diff[k*SLICE +: SLICE] and borrow_next to the borrow register; counter increments.
  - On the edge with k == NSLICE-1: bout = borrow_next; ovf and zero are evaluated on the complete diff, including the slice written that edge. State goes to DONE.
- Latency: the acceptance edge is T. Slices are computed at edges T+1..T+NSLICE. out_valid is high after edge T+NSLICE (4 cycles for the defaults).
- DONE:
  - diff, bout, ovf and zero are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE. Result registers keep their last values; out_valid drops.
  - in_ready stays 0 throughout DONE, so no overlap with a new transaction. The earliest next accept is the edge after the cycle where IDLE is entered.
- in_valid during RUN or DONE is ignored; the sampled operands are never disturbed.
- Operand inputs are sampled only on the acceptance edge. Input changes after acceptance have no effect.
- rst_n asserted mid-RUN or in DONE aborts the operation. Partial results are discarded and all outputs return to their reset values immediately.
- out_ready while not in DONE has no effect.
- diff wraps modulo 2^WIDTH. The borrow ripples through all slices; no early termination.
- Partially written diff bits may be visible during RUN. They are valid only when out_valid=1.

Test Plan:
1. Basic subtract: a=0x00000005, b=0x00000003, bin=0, accept at T. Required: out_valid rises after edge T+4; diff=0x00000002, bout=0, ovf=0, zero=0.
2. Full borrow ripple: a=0x00000000, b=0x00000001, bin=0. Required: diff=0xFFFFFFFF, bout=1, ovf=0, zero=0. Also run a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1. Required: diff=0xFFFFFFFF, bout=1.
3. Signed overflow: a=0x80000000, b=0x00000001, bin=0. Required: diff=0x7FFFFFFF, bout=0, ovf=1. Also run a=0x7FFFFFFF, b=0xFFFFFFFF. Required: diff=0x80000000, bout=1, ovf=1.
4. Zero with borrow-in: a=0x12345678, b=0x12345677, bin=1. Required: diff=0x00000000, zero=1, bout=0, ovf=0.
5. Backpressure and ignored input:
   - Hold out_ready=0 for 3 cycles in DONE. Required: outputs constant, in_ready=0.
   - Toggle in_valid with new operands during RUN. Required: result still matches the first operands.
   - Raise out_ready. Required: IDLE, in_ready=1 next cycle.
6. Reset mid-operation: accept a=0x0FFFFFFF, b=0xFDBACE01, drop rst_n after 2 RUN edges. Required: out_valid=0, in_ready=1, diff=0 immediately. A fresh transaction with the same operands then gives diff=0x124531FE, bout=1.
